// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide engine with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN to compute the four multiplies combinationally in one cycle.
module muldiv_unit #(
   parameter int XLEN = 32,
   parameter int ITER_CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam logic [4:0] ALU_MUL    = 5'd16;
   localparam logic [4:0] ALU_MULH   = 5'd17;
   localparam logic [4:0] ALU_MULHSU = 5'd18;
   localparam logic [4:0] ALU_MULHU  = 5'd19;
   localparam logic [4:0] ALU_DIV    = 5'd20;
   localparam logic [4:0] ALU_DIVU   = 5'd21;
   localparam logic [4:0] ALU_REM    = 5'd22;
   localparam logic [4:0] ALU_REMU   = 5'd23;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [4:0] op_q;
   logic [XLEN-1:0] mb, stage, hold, a_mag, b_mag, dz_res, fast_res, run_res, div_res, q, r;
   logic [2*XLEN-1:0] p, p_nx, p_div;
   logic [ITER_CNT_W-1:0] cnt;
   logic [XLEN:0] rs, diff;
   logic neg_q, rneg_q, is_m, is_div, is_rem, q_rem, sgn_a, sgn_b, a_neg, b_neg, ovf, fast;

   assign is_m   = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   assign is_div = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   assign is_rem = op inside {ALU_REM, ALU_REMU};
   assign sgn_a  = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
   assign sgn_b  = op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
   assign a_neg  = sgn_a & a[XLEN-1];
   assign b_neg  = sgn_b & b[XLEN-1];
   assign a_mag  = a_neg ? -a : a;
   assign b_mag  = b_neg ? -b : b;
   assign ovf    = op inside {ALU_DIV, ALU_REM} && a == MIN_NEG && b == '1;
   assign dz_res = b == '0 ? (is_rem ? a : '1) : (is_rem ? '0 : MIN_NEG);

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*XLEN-1:0] fm;
   assign fm       = $signed({a_neg, a}) * $signed({b_neg, b});
   assign fast     = is_div ? (b == '0 || ovf) : is_m;
   assign fast_res = is_div ? dz_res : (op == ALU_MUL ? fm[XLEN-1:0] : fm[2*XLEN-1:XLEN]);
`else
   assign fast     = is_div && (b == '0 || ovf);
   assign fast_res = dz_res;
`endif

   // restoring step: shift next dividend bit into the partial remainder, keep it if the subtract goes negative
   assign rs    = p[2*XLEN-1:XLEN-1];
   assign diff  = rs - {1'b0, mb};
   assign p_div = diff[XLEN] ? {rs[XLEN-1:0], p[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
   assign q_rem = op_q inside {ALU_REM, ALU_REMU};
   assign q     = p_nx[XLEN-1:0];
   assign r     = p_nx[2*XLEN-1:XLEN];
   assign div_res = q_rem ? (rneg_q ? -r : r) : (neg_q ? -q : q);

`ifdef MULDIV_FAST_MUL_EN
   assign p_nx    = p_div;
   assign run_res = div_res;
`else
   logic [XLEN:0] mul_sum;
   logic [2*XLEN-1:0] prod;
   logic q_div;
   assign q_div   = op_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   assign mul_sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, mb} : '0);
   assign p_nx    = q_div ? p_div : {mul_sum, p[XLEN-1:1]};
   assign prod    = neg_q ? -p_nx : p_nx;
   assign run_res = q_div ? div_res : (op_q == ALU_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= '0;
         cnt    <= '0;
         p      <= '0;
         mb     <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         stage  <= '0;
         hold   <= '0;
      end else begin
         case (state)
            IDLE: if (start && !kill && is_m) begin
               op_q   <= op;
               neg_q  <= a_neg ^ b_neg;
               rneg_q <= a_neg;
               cnt    <= '0;
               if (fast) begin
                  stage <= fast_res;
                  state <= DONE;
               end else begin
                  p     <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                  mb    <= is_div ? b_mag : a_mag;
                  state <= RUN;
               end
            end
            RUN: if (kill) state <= IDLE;
            else begin
               p   <= p_nx;
               cnt <= cnt + 1'b1;
               if (cnt == ITER_CNT_W'(XLEN-1)) begin
                  stage <= run_res;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
               if (!kill) hold <= stage;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // a kill in DONE hides the pending result and the pulse in that same cycle
   assign busy   = state != IDLE;
   assign done   = state == DONE && !kill;
   assign result = done ? stage : hold;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic RV32M model.
module tb_muldiv_unit;
   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_MUL    = 5'd16;
   localparam logic [4:0] ALU_MULH   = 5'd17;
   localparam logic [4:0] ALU_MULHSU = 5'd18;
   localparam logic [4:0] ALU_MULHU  = 5'd19;
   localparam logic [4:0] ALU_DIV    = 5'd20;
   localparam logic [4:0] ALU_DIVU   = 5'd21;
   localparam logic [4:0] ALU_REM    = 5'd22;
   localparam logic [4:0] ALU_REMU   = 5'd23;

   logic clk = 1'b0, rst, start, kill, busy, done;
   logic [4:0] op;
   logic [31:0] a, b, result, last;
   int n_assert = 0, n_fail = 0;
   bit saw;

   muldiv_unit dut (.clk(clk), .rst(rst), .start(start), .kill(kill), .op(op), .a(a), .b(b),
                    .busy(busy), .done(done), .result(result));

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx = $signed(x);
      longint sy = $signed(y);
      longint ux = {32'd0, x};
      longint uy = {32'd0, y};
      logic [63:0] pr;
      bit ov = x == 32'h80000000 && y == 32'hFFFFFFFF;
      case (o)
         ALU_MUL:    return x * y;
         ALU_MULH:   begin pr = sx * sy; return pr[63:32]; end
         ALU_MULHSU: begin pr = sx * uy; return pr[63:32]; end
         ALU_MULHU:  begin pr = ux * uy; return pr[63:32]; end
         ALU_DIV:    return y == 0 ? 32'hFFFFFFFF : ov ? 32'h80000000 : 32'(sx / sy);
         ALU_DIVU:   return y == 0 ? 32'hFFFFFFFF : x / y;
         ALU_REM:    return y == 0 ? x : ov ? 32'd0 : 32'(sx % sy);
         ALU_REMU:   return y == 0 ? x : x % y;
         default:    return 32'd0;
      endcase
   endfunction

   function automatic int lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      bit dv = o inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      bit ov = o inside {ALU_DIV, ALU_REM} && x == 32'h80000000 && y == 32'hFFFFFFFF;
      if (dv && (y == 0 || ov)) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!dv) return 1;
`endif
      return 33;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      @(negedge clk);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
   endtask

   // issues one op at a negedge, follows it to its done pulse; hold keeps start asserted throughout
   task automatic run(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input bit hold);
      logic [31:0] er = model(o, x, y);
      int el = lat(o, x, y);
      int kd = 0;
      bit bad = 0;
      op = o; a = x; b = y; start = 1'b1;
      for (int k = 1; k <= 40 && kd == 0; k++) begin
         @(negedge clk);
         if (!hold) begin start = 1'b0; a = $urandom; b = $urandom; end
         if (done) kd = k;
         if (busy !== 1'b1) bad = 1;
      end
      check($sformatf("lat op%0d", o), 32'(kd), 32'(el));
      check($sformatf("res op%0d %h %h", o, x, y), result, er);
      check("busy_run", {31'd0, bad}, 32'd0);
      last = er;
      if (!hold) idle_chk("after");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; kill = 1'b0; op = ALU_ADD; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run(ALU_MUL, 32'd7, 32'hFFFFFFFD, 0);
      run(ALU_MULH, 32'h80000000, 32'h80000000, 0);
      run(ALU_MULHU, 32'h80000000, 32'h80000000, 0);
      run(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      run(ALU_DIV, -32'sd20, 32'd3, 0);
      run(ALU_REM, -32'sd20, 32'd3, 0);
      run(ALU_DIVU, 32'd100, 32'd7, 0);
      run(ALU_REMU, 32'd100, 32'd7, 0);
      run(ALU_DIV, 32'd5, 32'd0, 0);
      run(ALU_REM, 32'd5, 32'd0, 0);
      run(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
      run(ALU_REM, 32'h80000000, 32'hFFFFFFFF, 0);
      run(ALU_DIVU, 32'd100, 32'd7, 0);

      // kill mid-run: no pulse, result keeps the last value
      op = ALU_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1; saw = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) saw = 1;
         if (k == 10) kill = 1'b1;
      end
      @(negedge clk);
      kill = 1'b0;
      check("kill_busy", {31'd0, busy}, 32'd0);
      check("kill_result", result, last);
      repeat (3) begin @(negedge clk); if (done || busy) saw = 1; end
      check("kill_quiet", {31'd0, saw}, 32'd0);

      // reset mid-run clears the result
      op = ALU_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1; saw = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) saw = 1;
         if (k == 10) begin rst = 1'b1; kill = 1'b1; end
      end
      @(negedge clk);
      rst = 1'b0; kill = 1'b0;
      check("rstmid_busy", {31'd0, busy}, 32'd0);
      check("rstmid_result", result, 32'd0);
      check("rstmid_nodone", {31'd0, saw | done}, 32'd0);
      last = 32'd0;

      // non-M op is ignored
      op = ALU_ADD; a = 32'd1; b = 32'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("add_busy", {31'd0, busy}, 32'd0);
      idle_chk("add");

      // kill beats start in IDLE
      op = ALU_DIVU; a = 32'd9; b = 32'd2; start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check("killstart_busy", {31'd0, busy}, 32'd0);
      check("killstart_result", result, last);
      @(negedge clk);

      // start held through RUN and DONE, then a back-to-back start right after DONE
      run(ALU_MULHU, 32'h80000000, 32'h80000000, 1);
      @(negedge clk);
      check("b2b_gap_busy", {31'd0, busy}, 32'd0);
      check("b2b_gap_done", {31'd0, done}, 32'd0);
      run(ALU_DIV, -32'sd20, 32'd3, 0);

      for (int i = 0; i < 48; i++) begin
         logic [4:0] ro;
         logic [31:0] rx, ry;
         ro = 5'(16 + $urandom_range(0, 7));
         rx = $urandom_range(0, 5) == 0 ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 5))
            0: ry = 32'd0;
            1: ry = 32'hFFFFFFFF;
            2: ry = 32'($urandom_range(1, 15));
            default: ry = $urandom;
         endcase
         run(ro, rx, ry, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
